// File: rtl/drfm_dac_pkg.sv
// rtl/drfm_dac_pkg.sv - shared constants, limits and state type for the DAC output formatter
package drfm_dac_pkg;

    localparam int IN_W_DEF       = 33;
    localparam int DAC_W_DEF      = 14;
    localparam int SHIFT_W_DEF    = 5;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    // Offset-binary mid-scale and the signed clamp limits for the DAC word
    localparam logic [DAC_W_DEF-1:0]        DAC_MID   = 14'h2000;
    localparam logic signed [DAC_W_DEF-1:0] DAC_MAX_S = 14'sh1FFF;
    localparam logic signed [DAC_W_DEF-1:0] DAC_MIN_S = 14'sh2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word-fall-through FIFO with flush and extra-bit pointers
module sample_fifo
    import drfm_dac_pkg::*;
#(
    parameter int W     = DAC_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A push on full only lands when a pop frees the head slot in the same cycle
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer update; flush empties the FIFO without touching storage
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head is always presented; full/empty distinguished by the extra pointer bit
    always_comb begin
        rdata = mem[rd_ptr[AW-1:0]];
        count = wr_ptr - rd_ptr;
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

endmodule

// File: rtl/dac_output_formatter.sv
// rtl/dac_output_formatter.sv - gain/round, saturate, offset-binary convert and buffer samples for the DAC
module dac_output_formatter
    import drfm_dac_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int DAC_W      = DAC_W_DEF,
    parameter int SHIFT_W    = SHIFT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               M100CLK,
    input  logic               reset,
    input  logic               enable,
    input  logic [IN_W-1:0]    sum,
    input  logic               in_valid,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               dac_rd,
    output logic [DAC_W-1:0]   dac_data,
    output logic               dac_valid,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   sat_count,
    output logic               ovf_flag,
    output logic               udf_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t state;
    state_t state_next;

    logic                   accept;
    logic signed [IN_W:0]   sum_ext;
    logic signed [IN_W:0]   rnd;
    logic signed [IN_W:0]   rounded;
    logic signed [IN_W:0]   shifted;

    logic                   s1_valid;
    logic signed [IN_W:0]   s1_data;

    logic [IN_W-DAC_W+1:0]  hi_bits;
    logic                   clip;
    logic [DAC_W-1:0]       clamped;
    logic [DAC_W-1:0]       offset_word;

    logic                   push;
    logic                   pop;
    logic                   flush;
    logic [DAC_W-1:0]       head;
    logic [AW:0]            fifo_count;
    logic                   fifo_empty;
    logic [DAC_W-1:0]       last_data;

    // Stage 1 datapath: one guard bit so adding the half-LSB can never wrap
    always_comb begin
        accept  = in_valid && enable && (state != IDLE);
        sum_ext = {sum[IN_W-1], sum};
        rnd     = '0;
        if (shift != '0) rnd = (IN_W+1)'(1) << (shift - SHIFT_W'(1));
        rounded = sum_ext + rnd;
        shifted = rounded >>> shift;
    end

    // Stage 1 register; anything in flight is dropped when the block is disabled
    always_ff @(posedge M100CLK) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_data <= shifted;
        end
    end

    // Stage 2 datapath: in range only when all bits above the DAC sign bit match it
    always_comb begin
        hi_bits     = s1_data[IN_W:DAC_W-1];
        clip        = !((&hi_bits) || !(|hi_bits));
        clamped     = s1_data[DAC_W-1:0];
        if (clip) clamped = s1_data[IN_W] ? DAC_W'(DAC_MIN_S) : DAC_W'(DAC_MAX_S);
        offset_word = {~clamped[DAC_W-1], clamped[DAC_W-2:0]};
        push        = s1_valid && enable && (state != IDLE);
        flush       = (state == IDLE);
        dac_valid   = (state == RUN) && !fifo_empty;
        pop         = dac_rd && dac_valid;
        dac_data    = dac_valid ? head : last_data;
    end

    sample_fifo #(
        .W     (DAC_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (M100CLK),
        .resetn (reset),
        .flush  (flush),
        .push   (push),
        .wdata  (offset_word),
        .pop    (pop),
        .rdata  (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sticky flags, saturating clip counter and the held output word
    always_ff @(posedge M100CLK) begin
        if (!reset) begin
            sat_count <= '0;
            ovf_flag  <= 1'b0;
            udf_flag  <= 1'b0;
            last_data <= DAC_W'(DAC_MID);
        end else begin
            if (push && clip && (sat_count != '1)) sat_count <= sat_count + CNT_W'(1);
            if (push && fifo_full && !pop) ovf_flag <= 1'b1;
            if (dac_rd && (state == RUN) && fifo_empty) udf_flag <= 1'b1;
            if (pop) last_data <= head;
        end
    end

    // State register
    always_ff @(posedge M100CLK) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: prime until half full, then run; disable always returns to idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   if (fifo_count >= (AW+1)'(FIFO_DEPTH/2)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

endmodule

// File: doc/dac_output_formatter.md
Name: dac_output_formatter

Overview:
Downstream stage of the I/Q adder. It takes the 33-bit two's-complement sum stream and applies a programmable power-of-two gain with round-half-up. It then saturates the result to DAC width, converts it to offset binary, and buffers samples in a small FIFO. The DAC interface drains the FIFO one word per strobe, with a priming state machine, overflow/underflow flags and a saturation counter.

Parameters:
IN_W, 33, input sample width (two's complement)
DAC_W, 14, DAC word width (offset binary)
SHIFT_W, 5, width of gain right-shift control
FIFO_DEPTH, 8, FIFO entries; power of two, >=4
CNT_W, 16, saturation counter width

Ports:
M100CLK  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  1 = run; 0 = flush and idle
sum  in  IN_W  two's-complement sample from adder
in_valid  in  1  sum valid this cycle
shift  in  SHIFT_W  right-shift amount, sampled with each in_valid
dac_rd  in  1  DAC strobe; pops head word when dac_valid=1
dac_data  out  DAC_W  FIFO head, offset binary
dac_valid  out  1  dac_data is valid
fifo_full  out  1  FIFO holds FIFO_DEPTH words
sat_count  out  CNT_W  samples clipped since reset; sticks at all-ones
ovf_flag  out  1  sticky: sample dropped on full FIFO
udf_flag  out  1  sticky: dac_rd while dac_valid=0 in RUN

Behaviour:
- Reset (reset=0 at clock edge):
  - dac_data=mid-scale 2^(DAC_W-1) (14'h2000), dac_valid=0, fifo_full=0, sat_count=0, ovf_flag=0, udf_flag=0.
  - Pointers and pipeline valids cleared; state=IDLE.
  - Reset mid-stream discards all buffered and in-flight samples.
- Stage 1 (registered):
  - Extend sum to IN_W+1 bits. If shift>0, add 2^(shift-1).
  - Arithmetic right shift by shift, giving round-half-up (-1.5 -> -1, +1.5 -> +2).
  - The extra bit guarantees the rounding add never wraps.
- Stage 2 (registered):
  - Clamp to [-2^(DAC_W-1), 2^(DAC_W-1)-1].
  - On clip, sat_count increments unless already all-ones.
  - Convert to offset binary by inverting the MSB.
- Stage 3: FIFO write. Latency is in_valid at cycle t -> write at edge t+2 -> visible as head at t+3.
- FIFO is first-word-fall-through: dac_data always shows the head word while dac_valid=1.
- Read and write boundary cases:
  - Write on full with no pop: sample dropped, ovf_flag set.
  - Write on full with a pop in the same cycle: both occur, count unchanged.
  - Read and write on empty: the written word is not readable until the next cycle.
- State machine:
  - IDLE: dac_valid=0, FIFO flushed, pipeline inputs ignored. enable=1 -> PRIME.
  - PRIME: accepts samples, dac_valid=0. FIFO count >= FIFO_DEPTH/2 -> RUN.
  - RUN: dac_valid=(count!=0).
    - dac_rd with count=0 sets udf_flag and stays in RUN.
    - dac_data holds its last value; mid-scale if nothing has been read yet.
  - Any state with enable=0: next state IDLE, FIFO flushed the following edge, in-flight pipeline samples discarded. Flags and sat_count are retained.
- dac_rd in IDLE/PRIME is ignored and sets no flag.
- Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.

Decomposition:
- Package drfm_dac_pkg holds the following; parameters default from the package:
  - DAC_MID constant.
  - DAC_MAX_S and DAC_MIN_S signed limits.
  - State enum {IDLE, PRIME, RUN}.
- One sub-module: sample_fifo, a parameterised FWFT FIFO. It provides push/pop/count/full/empty, a synchronous active-low reset and a flush input.

Test Plan:
- Reset held 3 cycles, then released -> dac_data=14'h2000, dac_valid=0, sat_count=0, ovf_flag=0, udf_flag=0.
- enable=1, sum=4096, shift=0, 4 samples -> RUN after 4th write; dac_data=14'h3000; pops return 4 words then dac_valid=0.
- sum=-24 and +24 with shift=4 -> offset words 14'h1FFF (-1) and 14'h2002 (+2), confirming round-half-up.
- sum=+2^31, then -2^32, shift=0 -> 14'h3FFF then 14'h0000; sat_count=2.
- 10 samples with no dac_rd -> fifo_full=1 after 8, ovf_flag=1; 8 pops return the first 8 samples in order.
- In RUN, drain to empty and assert dac_rd -> udf_flag=1. Drop enable mid-stream -> next edge IDLE, dac_valid=0, flags unchanged.
